// File: rtl/regfile_mp.sv
// Multi-ported register file: two write ports, two combinational read ports,
// per-register pending (load-outstanding) bits with a running pending count.
module regfile_mp #(
  parameter int DATA_W  = 16,
  parameter int NREG    = 8,
  parameter int AW      = $clog2(NREG),
  parameter bit ZERO_R0 = 1'b0,
  parameter bit BYPASS  = 1'b1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           i_we0,
  input  logic [AW-1:0]                  i_wa0,
  input  logic [DATA_W-1:0]              i_wd0,
  input  logic                           i_we1,
  input  logic [AW-1:0]                  i_wa1,
  input  logic [DATA_W-1:0]              i_wd1,
  input  logic [AW-1:0]                  i_addrx,
  input  logic [AW-1:0]                  i_addry,
  output logic [DATA_W-1:0]              o_datax,
  output logic [DATA_W-1:0]              o_datay,
  input  logic                           i_busy_set,
  input  logic [AW-1:0]                  i_busy_addr,
  output logic                           o_busyx,
  output logic                           o_busyy,
  output logic [AW:0]                    o_nbusy,
  output logic [NREG-1:0][DATA_W-1:0]    tb_regs
);

  logic [NREG-1:0][DATA_W-1:0] regs;
  logic [NREG-1:0]             pend;
  logic [NREG-1:0]             pend_nxt;
  logic [AW:0]                 nbusy;
  logic                        we0_ok;
  logic                        we1_ok;
  logic                        set_ok;
  logic                        inc;
  logic                        dec;

  // With ZERO_R0, anything aimed at register 0 is squashed at the source.
  assign we0_ok = i_we0 && !(ZERO_R0 && (i_wa0 == '0));
  assign we1_ok = i_we1 && !(ZERO_R0 && (i_wa1 == '0));
  assign set_ok = i_busy_set && !(ZERO_R0 && (i_busy_addr == '0));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      regs <= '0;
    end else begin
      if (we1_ok) regs[i_wa1] <= i_wd1;
      // Port 0 assigned last so it wins an address collision.
      if (we0_ok) regs[i_wa0] <= i_wd0;
    end
  end

  always_comb begin
    pend_nxt = pend;
    if (i_we1)  pend_nxt[i_wa1] = 1'b0;
    if (set_ok) pend_nxt[i_busy_addr] = 1'b1;
  end

  // Count moves only on real transitions; a set and clear hitting the same
  // register resolve to the set, so that clear never decrements.
  assign inc = set_ok && !pend[i_busy_addr];
  assign dec = i_we1 && pend[i_wa1] && !(set_ok && (i_busy_addr == i_wa1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend  <= '0;
      nbusy <= '0;
    end else begin
      pend  <= pend_nxt;
      nbusy <= nbusy + {{AW{1'b0}}, inc} - {{AW{1'b0}}, dec};
    end
  end

  always_comb begin
    o_datax = regs[i_addrx];
    if (BYPASS) begin
      if (we1_ok && (i_wa1 == i_addrx)) o_datax = i_wd1;
      if (we0_ok && (i_wa0 == i_addrx)) o_datax = i_wd0;
    end
  end

  always_comb begin
    o_datay = regs[i_addry];
    if (BYPASS) begin
      if (we1_ok && (i_wa1 == i_addry)) o_datay = i_wd1;
      if (we0_ok && (i_wa0 == i_addry)) o_datay = i_wd0;
    end
  end

  assign o_busyx = pend[i_addrx];
  assign o_busyy = pend[i_addry];
  assign o_nbusy = nbusy;
  assign tb_regs = regs;

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: two instances (bypass / zero-r0 no-bypass) driven in
// parallel and compared against an array-based model every cycle.
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        reset;
  logic        we0, we1, bset;
  logic [2:0]  wa0, wa1, addrx, addry, baddr;
  logic [15:0] wd0, wd1;

  logic [15:0]          dx [2];
  logic [15:0]          dy [2];
  logic                 bx [2];
  logic                 by [2];
  logic [3:0]           nb [2];
  logic [7:0][15:0]     tbr [2];

  logic [15:0] m_regs [2][8];
  logic [7:0]  m_pend [2];

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  regfile_mp #(.DATA_W(16), .NREG(8), .ZERO_R0(1'b0), .BYPASS(1'b1)) dut_b (
    .clk(clk), .reset(reset),
    .i_we0(we0), .i_wa0(wa0), .i_wd0(wd0),
    .i_we1(we1), .i_wa1(wa1), .i_wd1(wd1),
    .i_addrx(addrx), .i_addry(addry),
    .o_datax(dx[0]), .o_datay(dy[0]),
    .i_busy_set(bset), .i_busy_addr(baddr),
    .o_busyx(bx[0]), .o_busyy(by[0]),
    .o_nbusy(nb[0]), .tb_regs(tbr[0])
  );

  regfile_mp #(.DATA_W(16), .NREG(8), .ZERO_R0(1'b1), .BYPASS(1'b0)) dut_z (
    .clk(clk), .reset(reset),
    .i_we0(we0), .i_wa0(wa0), .i_wd0(wd0),
    .i_we1(we1), .i_wa1(wa1), .i_wd1(wd1),
    .i_addrx(addrx), .i_addry(addry),
    .o_datax(dx[1]), .o_datay(dy[1]),
    .i_busy_set(bset), .i_busy_addr(baddr),
    .o_busyx(bx[1]), .o_busyy(by[1]),
    .o_nbusy(nb[1]), .tb_regs(tbr[1])
  );

  function automatic bit zr(input int k);
    return k == 1;
  endfunction

  function automatic bit bp(input int k);
    return k == 0;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_zero();
    for (int k = 0; k < 2; k++) begin
      for (int r = 0; r < 8; r++) m_regs[k][r] = '0;
      m_pend[k] = '0;
    end
  endtask

  // What a read port must show given the current inputs and model contents.
  function automatic logic [15:0] exp_rd(input int k, input logic [2:0] a);
    if (zr(k) && a == 3'd0) return 16'h0;
    if (bp(k)) begin
      if (we0 && wa0 == a) return wd0;
      if (we1 && wa1 == a) return wd1;
    end
    return m_regs[k][a];
  endfunction

  function automatic int popcnt(input logic [7:0] v);
    int c = 0;
    for (int i = 0; i < 8; i++) c += int'(v[i]);
    return c;
  endfunction

  task automatic model_update();
    if (reset) begin
      model_zero();
      return;
    end
    for (int k = 0; k < 2; k++) begin
      if (we1 && !(zr(k) && wa1 == 3'd0)) m_regs[k][wa1] = wd1;
      if (we0 && !(zr(k) && wa0 == 3'd0)) m_regs[k][wa0] = wd0;
      if (we1) m_pend[k][wa1] = 1'b0;
      if (bset && !(zr(k) && baddr == 3'd0)) m_pend[k][baddr] = 1'b1;
    end
  endtask

  task automatic check_model();
    for (int k = 0; k < 2; k++) begin
      chk("datax", dx[k], exp_rd(k, addrx));
      chk("datay", dy[k], exp_rd(k, addry));
      chk("busyx", bx[k], m_pend[k][addrx]);
      chk("busyy", by[k], m_pend[k][addry]);
      chk("nbusy", nb[k], popcnt(m_pend[k]));
      for (int r = 0; r < 8; r++) chk("tb_regs", tbr[k][r], m_regs[k][r]);
    end
  endtask

  task automatic idle();
    we0 = 0; we1 = 0; bset = 0;
    wa0 = 0; wa1 = 0; wd0 = 0; wd1 = 0; baddr = 0;
    addrx = 0; addry = 0;
  endtask

  // Called with inputs already set in the low phase; returns at next negedge.
  task automatic tick();
    #1 check_model();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    idle();
    model_zero();
    #1;
    chk("reset_nbusy", nb[0], 0);
    chk("reset_regs", tbr[0] == '0, 1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Bypass write visible same cycle; stored value the cycle after.
    we0 = 1; wa0 = 3; wd0 = 16'hBEEF; addrx = 3;
    #1 chk("bypass_x", dx[0], 16'hBEEF);
    chk("nobypass_old", dx[1], 16'h0);
    tick();
    idle(); addrx = 3;
    #1 chk("nobypass_new", dx[1], 16'hBEEF);
    chk("stored3", tbr[0][3], 16'hBEEF);

    // Write collision: port 0 wins.
    we0 = 1; wa0 = 5; wd0 = 16'h1111; we1 = 1; wa1 = 5; wd1 = 16'h2222; addry = 5;
    #1 chk("collide_bypass", dy[0], 16'h1111);
    tick();
    idle(); addry = 5;
    #1 chk("collide_store", tbr[0][5], 16'h1111);
    chk("collide_read", dy[1], 16'h1111);

    // Register 0 hardwired in the ZERO_R0 instance.
    we0 = 1; wa0 = 0; wd0 = 16'hFFFF; bset = 1; baddr = 0; addrx = 0;
    #1 chk("r0_bypass", dx[1], 16'h0);
    tick();
    idle();
    #1 chk("r0_store", tbr[1][0], 16'h0);
    chk("r0_nbusy", nb[1], 0);
    chk("r0_plain_nbusy", nb[0], 1);
    we1 = 1; wa1 = 0; wd1 = 16'h0;
    tick();

    // Pending bookkeeping.
    idle(); bset = 1; baddr = 2; tick();
    idle(); bset = 1; baddr = 4; tick();
    idle(); bset = 1; baddr = 6; tick();
    idle();
    #1 chk("nbusy3", nb[0], 3);
    chk("nbusy3_z", nb[1], 3);
    we1 = 1; wa1 = 4; wd1 = 16'h1234; addrx = 4;
    #1 chk("busy_no_bypass", bx[0], 1);
    tick();
    idle(); addrx = 4;
    #1 chk("busy_cleared", bx[0], 0);
    chk("nbusy2", nb[0], 2);

    // Set and clear on the same register: set wins, data stored.
    bset = 1; baddr = 7; we1 = 1; wa1 = 7; wd1 = 16'h7777;
    tick();
    idle(); addrx = 7;
    #1 chk("setclr_nbusy", nb[0], 3);
    chk("setclr_data", tbr[0][7], 16'h7777);
    chk("setclr_busy", bx[0], 1);
    idle(); bset = 1; baddr = 1; tick();
    idle();
    #1 chk("nbusy4", nb[0], 4);

    // Asynchronous reset between edges, then held through an edge.
    #1 reset = 1'b1;
    model_zero();
    #1 chk("async_nbusy", nb[0], 0);
    chk("async_regs", tbr[0] == '0, 1);
    we0 = 1; wa0 = 2; wd0 = 16'hAAAA; addrx = 2;
    #1 chk("reset_bypass", dx[0], 16'hAAAA);
    tick();
    reset = 1'b0;
    idle(); we1 = 1; wa1 = 2; wd1 = 16'h5A5A; addrx = 2;
    tick();
    idle(); addrx = 2;
    #1 chk("post_reset_store", tbr[0][2], 16'h5A5A);
    chk("post_reset_busy", bx[0], 0);
    chk("post_reset_nbusy", nb[0], 0);

    // Randomized traffic, occasional reset pulses.
    for (int n = 0; n < 600; n++) begin
      we0   = 1'($urandom_range(0, 1));
      we1   = 1'($urandom_range(0, 1));
      bset  = 1'($urandom_range(0, 1));
      wa0   = 3'($urandom);
      wa1   = 3'($urandom);
      baddr = 3'($urandom);
      addrx = 3'($urandom);
      addry = 3'($urandom);
      wd0   = 16'($urandom);
      wd1   = 16'($urandom);
      reset = ($urandom_range(0, 59) == 0);
      if (reset) model_zero();
      tick();
    end
    reset = 1'b0;
    idle();
    #1 check_model();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
